// File: rtl/div_by_n_sched.sv
// Round-robin front end for one shared serial residue engine.
// It accepts one word, shifts it through the engine MSB-first, then holds the result until it is taken.
module div_by_n_sched #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int DIVISOR = 3,
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int RW = $clog2(DIVISOR)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    input  logic [NUM_REQ*WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [IW-1:0]            rsp_id_o,
    output logic [RW-1:0]            rsp_rem_o,
    output logic                     rsp_div_o,
    output logic                     busy_o
);

    // state    | meaning
    // ST_IDLE  | arbitrating; ready is offered to the round-robin winner
    // ST_SHIFT | feeding the captured word into the residue engine, one bit per cycle
    // ST_RESP  | result held on the response port until the handshake
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [RW:0] DIV_C = (RW+1)'(DIVISOR);

    logic [1:0]           state;
    logic [IW-1:0]        ptr;
    logic [IW-1:0]        id;
    logic [WIDTH-1:0]     sreg;
    logic [CW-1:0]        cnt;
    logic [RW-1:0]        rem;

    logic [2*NUM_REQ-1:0] rot;
    logic                 gnt_found;
    logic [IW-1:0]        gnt_idx;
    logic [IW-1:0]        ptr_nxt;
    logic [WIDTH-1:0]     gnt_data;
    int                   sum;
    logic [RW:0]          t;
    logic [RW-1:0]        rem_nxt;

    // Rotating the doubled valid vector puts the pointer position at bit 0,
    // so the first set bit is the round-robin winner.
    always_comb begin
        rot       = {req_valid_i, req_valid_i} >> ptr;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        sum       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!gnt_found && rot[i]) begin
                gnt_found = 1'b1;
                sum       = int'(ptr) + i;
                if (sum >= NUM_REQ) begin
                    sum = sum - NUM_REQ;
                end
                gnt_idx = IW'(sum);
            end
        end
    end

    always_comb begin
        ptr_nxt  = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + IW'(1);
        gnt_data = req_data_i[int'(gnt_idx)*WIDTH +: WIDTH];
    end

    // rem < DIVISOR, so 2*rem+bit < 2*DIVISOR and one conditional subtract reduces it.
    always_comb begin
        t       = {rem, sreg[WIDTH-1]};
        rem_nxt = (t >= DIV_C) ? RW'(t - DIV_C) : RW'(t);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            ptr   <= '0;
            id    <= '0;
            sreg  <= '0;
            cnt   <= '0;
            rem   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gnt_found) begin
                        sreg  <= gnt_data;
                        id    <= gnt_idx;
                        rem   <= '0;
                        cnt   <= CW'(WIDTH - 1);
                        ptr   <= ptr_nxt;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    rem  <= rem_nxt;
                    sreg <= sreg << 1;
                    cnt  <= cnt - CW'(1);
                    if (cnt == '0) begin
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Ready is suppressed while reset is asserted so nothing looks accepted on a reset edge.
    always_comb begin
        req_ready_o = '0;
        if (reset_n && state == ST_IDLE && gnt_found) begin
            req_ready_o = NUM_REQ'(1) << gnt_idx;
        end
    end

    assign rsp_valid_o = (state == ST_RESP);
    assign rsp_id_o    = id;
    assign rsp_rem_o   = rem;
    assign rsp_div_o   = (state == ST_RESP) && (rem == '0);
    assign busy_o      = (state != ST_IDLE);

endmodule

// File: tb/tb_div_by_n_sched.sv
// Bench for div_by_n_sched: a transaction-level model checks every cycle, directed tests pin it.
// A second single-requester, modulus-5 instance covers the DIVISOR=5 and NUM_REQ=1 cases.
module tb_div_by_n_sched;

    localparam int N = 4;
    localparam int W = 8;
    localparam int D = 3;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [1:0]     rsp_id;
    logic [1:0]     rsp_rem;
    logic           rsp_div;
    logic           busy;

    logic           v5;
    logic [7:0]     d5;
    logic           ready5;
    logic           rv5;
    logic           rr5;
    logic           id5;
    logic [2:0]     rem5;
    logic           div5;
    logic           busy5;

    always #5 clk = ~clk;

    div_by_n_sched #(.NUM_REQ(N), .WIDTH(W), .DIVISOR(D)) u_dut (
        .clk(clk), .reset_n(reset_n), .req_valid_i(req_valid), .req_data_i(req_data),
        .req_ready_o(req_ready), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_id_o(rsp_id), .rsp_rem_o(rsp_rem), .rsp_div_o(rsp_div), .busy_o(busy)
    );

    div_by_n_sched #(.NUM_REQ(1), .WIDTH(8), .DIVISOR(5)) u_dut5 (
        .clk(clk), .reset_n(reset_n), .req_valid_i(v5), .req_data_i(d5),
        .req_ready_o(ready5), .rsp_valid_o(rv5), .rsp_ready_i(rr5),
        .rsp_id_o(id5), .rsp_rem_o(rem5), .rsp_div_o(div5), .busy_o(busy5)
    );

    int vecs = 0;
    int errs = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction model: one word in flight; response due WIDTH+1 cycles after the accept cycle.
    int cyc = 0;
    int m_busy = 0;
    int m_ptr = 0;
    int m_acc = 0;
    int m_id = 0;
    int m_rem = 0;
    int rise_seen = 0;
    int n_acc = 0;
    int n_rsp = 0;
    int acc_q[$];
    int rise_q[$];
    int hs_q[$];
    int rid_q[$];
    int rrem_q[$];

    always @(negedge clk) begin
        int g;
        int k;
        logic [N-1:0] exp_ready;
        logic exp_rv;
        cyc++;
        g = -1;
        for (int i = 0; i < N; i++) begin
            k = (m_ptr + i) % N;
            if (g < 0 && req_valid[k]) g = k;
        end
        exp_ready = '0;
        if (reset_n && m_busy == 0 && g >= 0) exp_ready[g] = 1'b1;
        exp_rv = (m_busy != 0) && (cyc - m_acc >= W + 1);

        chk("req_ready", req_ready, exp_ready);
        chk("busy", busy, m_busy);
        chk("rsp_valid", rsp_valid, exp_rv);
        if (exp_rv) begin
            chk("rsp_id", rsp_id, m_id);
            chk("rsp_rem", rsp_rem, m_rem);
            chk("rsp_div", rsp_div, m_rem == 0);
        end
        if (m_busy != 0 && rsp_valid && rise_seen == 0) begin
            rise_q[rise_q.size()-1] = cyc;
            rise_seen = 1;
        end

        if (!reset_n) begin
            m_busy = 0;
            m_ptr  = 0;
        end else if (m_busy == 0) begin
            if (g >= 0) begin
                m_busy = 1;
                m_acc  = cyc;
                m_id   = g;
                m_rem  = int'(req_data[g*W +: W]) % D;
                m_ptr  = (g + 1) % N;
                rise_seen = 0;
                acc_q.push_back(cyc);
                rise_q.push_back(-1);
                n_acc++;
            end
        end else if (exp_rv && rsp_ready) begin
            m_busy = 0;
            hs_q.push_back(cyc);
            rid_q.push_back(m_id);
            rrem_q.push_back(m_rem);
            n_rsp++;
        end
    end

    task automatic wait_acc(input int target, input int limit);
        int n = 0;
        while (n_acc < target && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        if (n_acc < target) chk("accept_timeout", n_acc, target);
    endtask

    task automatic wait_rsp(input int target, input int limit);
        int n = 0;
        while (n_rsp < target && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        if (n_rsp < target) chk("response_timeout", n_rsp, target);
    endtask

    task automatic wait_rv5(input int limit);
        int n = 0;
        while (!rv5 && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        if (!rv5) chk("rsp5_timeout", rv5, 1);
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    initial begin
        int ba;
        int br;
        int n;
        logic [1:0] exp_rem3 [4];
        exp_rem3 = '{2'd0, 2'd1, 2'd2, 2'd0};

        reset_n = 1'b0; req_valid = '0; req_data = '0; rsp_ready = 1'b1;
        v5 = 1'b0; d5 = '0; rr5 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        req_valid = 4'hF;
        @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_rem", rsp_rem, 0);
        chk("rst_rsp_div", rsp_div, 0);
        chk("rst_ready5", ready5, 0);
        @(posedge clk); #1;
        req_valid = '0;
        reset_n = 1'b1;

        // 1: req0 = 9
        ba = n_acc; br = n_rsp;
        req_data[7:0] = 8'd9;
        req_valid = 4'b0001;
        @(negedge clk);
        chk("t1_ready_same_cycle", req_ready, 4'b0001);
        wait_acc(ba + 1, 5);
        req_valid = '0;
        wait_rsp(br + 1, 30);
        if (n_rsp > br) begin
            chk("t1_id", rid_q[br], 0);
            chk("t1_rem", rrem_q[br], 0);
            chk("t1_latency", rise_q[ba] - acc_q[ba], 9);
        end

        // 2: req1 = 200 (data changed after accept, stray valid while busy), then req2 = 0
        pulse_reset();
        ba = n_acc; br = n_rsp;
        req_data[15:8] = 8'd200;
        req_valid = 4'b0010;
        wait_acc(ba + 1, 5);
        req_valid = '0;
        req_data[15:8] = 8'd0;
        @(posedge clk); #1;
        req_valid = 4'b1000;
        @(posedge clk); #1;
        req_valid = '0;
        wait_rsp(br + 1, 30);
        if (n_rsp > br) begin
            chk("t2a_id", rid_q[br], 1);
            chk("t2a_rem", rrem_q[br], 2);
        end
        req_data[23:16] = 8'd0;
        req_valid = 4'b0100;
        wait_acc(ba + 2, 5);
        req_valid = '0;
        wait_rsp(br + 2, 30);
        if (n_rsp > br + 1) begin
            chk("t2b_id", rid_q[br+1], 2);
            chk("t2b_rem", rrem_q[br+1], 0);
        end

        // 3: all valid, data 3,4,5,6
        pulse_reset();
        ba = n_acc; br = n_rsp;
        req_data = {8'd6, 8'd5, 8'd4, 8'd3};
        req_valid = 4'hF;
        wait_acc(ba + 4, 60);
        req_valid = '0;
        wait_rsp(br + 4, 60);
        if (n_rsp >= br + 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("t3_id", rid_q[br+i], i);
                chk("t3_rem", rrem_q[br+i], exp_rem3[i]);
            end
            for (int i = 0; i < 3; i++) begin
                chk("t3_spacing", acc_q[ba+i+1] - acc_q[ba+i], 10);
            end
        end

        // 4: stall in RESP for 5 cycles with req0 still valid
        pulse_reset();
        ba = n_acc; br = n_rsp;
        rsp_ready = 1'b0;
        req_data[7:0] = 8'd7;
        req_valid = 4'b0001;
        wait_acc(ba + 1, 5);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_stall_valid", rsp_valid, 1);
            chk("t4_stall_ready", req_ready, 0);
            chk("t4_stall_id", rsp_id, 0);
            chk("t4_stall_rem", rsp_rem, 1);
            chk("t4_stall_div", rsp_div, 0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        wait_rsp(br + 1, 5);
        wait_acc(ba + 2, 5);
        req_valid = '0;
        if (n_acc >= ba + 2 && n_rsp > br) chk("t4_regrant_gap", acc_q[ba+1] - hs_q[br], 1);
        wait_rsp(br + 2, 30);

        // 5: reset on the 4th SHIFT cycle abandons the word
        pulse_reset();
        ba = n_acc; br = n_rsp;
        req_data[23:16] = 8'd10;
        req_valid = 4'b0100;
        wait_acc(ba + 1, 5);
        req_valid = '0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        chk("t5_busy", busy, 0);
        chk("t5_rsp_valid", rsp_valid, 0);
        req_valid = 4'b1100;
        @(negedge clk);
        chk("t5_ptr_zero", req_ready, 4'b0100);
        chk("t5_no_rsp", n_rsp, br);
        wait_acc(ba + 2, 5);
        req_valid = '0;
        wait_rsp(br + 1, 30);
        if (n_rsp > br) begin
            chk("t5_id", rid_q[br], 2);
            chk("t5_rem", rrem_q[br], 1);
        end

        // 6: modulus 5, single requester
        d5 = 8'hFF;
        v5 = 1'b1;
        @(negedge clk);
        chk("t6_ready5", ready5, 1);
        @(posedge clk); #1;
        v5 = 1'b0;
        wait_rv5(20);
        chk("t6a_rem5", rem5, 0);
        chk("t6a_div5", div5, 1);
        chk("t6a_id5", id5, 0);
        @(posedge clk); #1;
        chk("t6a_done5", rv5, 0);
        d5 = 8'd254;
        v5 = 1'b1;
        @(posedge clk); #1;
        v5 = 1'b0;
        wait_rv5(20);
        chk("t6b_rem5", rem5, 4);
        chk("t6b_div5", div5, 0);
        @(posedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs + 1);
        $fatal(1, "watchdog");
    end

endmodule
